col_output_packer: RTL and testbench

- Parametrised next-generation systolic-array column output controller.
- Collects per-lane results arriving diagonally skewed from the array's bottom edge. Reassembles them into complete rows using ping-pong row slots.
- Packs each row into OW-bit words and queues them in an output FIFO. Words are drained by a valid/read handshake toward the host/memory interface.

---
 rtl/col_output_packer_pkg.sv | 47 ++++
 rtl/col_output_packer_sync_fifo.sv | 108 ++++++++++
 rtl/col_output_packer.sv | 222 ++++++++++++++++++++++
 tb/tb_col_output_packer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/col_output_packer_pkg.sv
// -----------------------------------------------------------------------------
// col_out_pkg
// Shared definitions for the systolic-array column output packer:
//   - derived-width helpers (lanes per word, words per row, FIFO level width,
//     index width for a counter over N items)
//   - packer FSM state encoding
//   - parameter legality predicate, evaluated at elaboration by the users of
//     this package
// -----------------------------------------------------------------------------
package col_out_pkg;

    // Packer FSM: IDLE waits for the current read slot to fill, PACK is
    // part-way through emitting that slot's words.
    typedef enum logic {
        IDLE = 1'b0,
        PACK = 1'b1
    } pack_state_e;

    // Lanes carried by one output word.
    function automatic int calc_lpw(input int ow, input int dw);
        return ow / dw;
    endfunction

    // Output words needed to carry one full row.
    function automatic int calc_nw(input int ncol, input int dw, input int ow);
        return (ncol * dw) / ow;
    endfunction

    // FIFO occupancy width: must represent 0..depth inclusive.
    function automatic int calc_lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of an index over n items (never narrower than one bit).
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // All geometric constraints the packer relies on.
    function automatic bit params_legal(input int ncol, input int dw,
                                        input int ow, input int fdepth);
        return (ncol >= 1) && (dw >= 1) && (ow >= dw) &&
               ((ow % dw) == 0) && (((ncol * dw) % ow) == 0) &&
               (fdepth >= 2) && ((fdepth & (fdepth - 1)) == 0);
    endfunction

endpackage

// File: rtl/col_output_packer_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head word is held in a dedicated register
// so it reads as zero after reset/flush and keeps its last value when empty.
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   clr         synchronous flush (priority over push/pop)
//   push, din   write request and data; accepted if not full or popping
//   pop         read request; ignored while empty
//   dout        head word (valid while !empty)
//   full, empty occupancy flags
//   level       exact occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
    import col_out_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    if (!((DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0))) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [W-1:0]  head_q;
    logic          push_eff;
    logic          pop_eff;

    assign empty    = (level_q == '0);
    assign full     = (level_q == FULL_LVL);
    assign pop_eff  = pop & ~empty;
    // A push into a full FIFO is still legal when a pop frees a slot in the
    // same cycle.
    assign push_eff = push & (~full | pop_eff);

    // NOTE: storage arrays carry no reset; validity is tracked by the
    // pointers and level, so resetting the words would only add fan-out.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end

            if (push_eff && !pop_eff) begin
                level_q <= level_q + LVL_ONE;
            end else if (pop_eff && !push_eff) begin
                level_q <= level_q - LVL_ONE;
            end

            // Head update: a new word becomes head when the FIFO is empty or
            // its only entry is leaving; otherwise a pop exposes the next
            // stored entry. A pop of the last entry with no push leaves the
            // head register holding the old value.
            if (push_eff && (empty || (pop_eff && level_q == LVL_ONE))) begin
                head_q <= din;
            end else if (pop_eff && level_q != LVL_ONE) begin
                head_q <= mem[rd_ptr_q + PTR_ONE];
            end
        end
    end

    assign dout  = head_q;
    assign level = level_q;

endmodule

// File: rtl/col_output_packer.sv
// -----------------------------------------------------------------------------
// col_output_packer
// Column output controller for a systolic array. Lane results arrive with a
// diagonal skew; each lane steers its data into one of two ping-pong row slots
// via its own 1-bit write pointer. Completed slots are drained in order, packed
// into OW-bit words (lowest lane in the LSBs) and queued in a show-ahead FIFO.
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   clr         synchronous flush of all state (highest priority)
//   in_r, in_v  per-lane result data and valid strobes
//   rread       pop request, effective only while rvalid=1
//   out_r       FIFO head word
//   rvalid      FIFO non-empty
//   ovf         sticky: a lane datum was dropped because its slot was full
//   rows_done   rows fully packed into the FIFO (wraps at 2^16)
//   level       FIFO occupancy
// -----------------------------------------------------------------------------
module col_output_packer
    import col_out_pkg::*;
#(
    parameter int NCOL   = 8,
    parameter int DW     = 8,
    parameter int OW     = 32,
    parameter int FDEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            clr,
    input  logic [DW-1:0]                   in_r [NCOL],
    input  logic                            in_v [NCOL],
    input  logic                            rread,
    output logic [OW-1:0]                   out_r,
    output logic                            rvalid,
    output logic                            ovf,
    output logic [15:0]                     rows_done,
    output logic [calc_lvl_w(FDEPTH)-1:0]   level
);

    localparam int LPW = calc_lpw(OW, DW);
    localparam int NW  = calc_nw(NCOL, DW, OW);
    localparam int WIW = calc_idx_w(NW);
    localparam logic [WIW-1:0] LAST_W = WIW'(NW - 1);
    localparam logic [WIW-1:0] W_ONE  = WIW'(1);

    if (!params_legal(NCOL, DW, OW, FDEPTH)) begin : g_param_check
        $error("col_output_packer: illegal NCOL/DW/OW/FDEPTH combination");
    end

    // Row slot storage and fill tracking.
    logic [DW-1:0]   slot_data   [2][NCOL];
    logic [NCOL-1:0] slot_mask_q [2];
    logic [NCOL-1:0] slot_mask_d [2];
    logic [1:0]      slot_full;
    logic [NCOL-1:0] wp_q;          // per-lane target slot
    logic            rd_slot_q;     // next slot to drain

    logic [NCOL-1:0] lane_we;
    logic [NCOL-1:0] lane_drop;

    // Packer.
    pack_state_e     state_q, state_d;
    logic [WIW-1:0]  widx_q, widx_d;
    logic            emit;
    logic            push;
    logic            push_ok;
    logic            row_done;
    logic [NW-1:0][OW-1:0] row_words;

    logic            ovf_q;
    logic [15:0]     rows_done_q;

    logic            fifo_full;
    logic            fifo_empty;

    assign slot_full[0] = &slot_mask_q[0];
    assign slot_full[1] = &slot_mask_q[1];

    // -------------------------------------------------------------------------
    // Lane capture: accept if the lane's target slot position is still empty,
    // otherwise drop the datum and flag overflow.
    // -------------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lane_we   = '0;
        lane_drop = '0;
        for (int i = 0; i < NCOL; i++) begin
            if (in_v[i]) begin
                if (slot_mask_q[wp_q[i]][i]) begin
                    lane_drop[i] = 1'b1;
                end else begin
                    lane_we[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCOL; i++) begin
            if (lane_we[i]) begin
                slot_data[wp_q[i]][i] <= in_r[i];
            end
        end
    end

    // A slot being cleared by the packer cannot receive a lane write in the
    // same cycle (all its lanes are full), so set-after-clear ordering is safe.
    always_comb begin
        slot_mask_d = slot_mask_q;
        if (row_done) begin
            slot_mask_d[rd_slot_q] = '0;
        end
        for (int i = 0; i < NCOL; i++) begin
            if (lane_we[i]) begin
                slot_mask_d[wp_q[i]][i] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Word formation from the read slot: word w carries lanes w*LPW..+LPW-1.
    // -------------------------------------------------------------------------
    always_comb begin
        row_words = '0;
        for (int l = 0; l < NCOL; l++) begin
            row_words[l / LPW][(l % LPW) * DW +: DW] = slot_data[rd_slot_q][l];
        end
    end

    // -------------------------------------------------------------------------
    // Packer FSM. Word 0 is emitted in the same cycle IDLE sees a complete
    // slot, giving one-edge latency from the last lane to the first word.
    // -------------------------------------------------------------------------
    assign push_ok = ~fifo_full | (rread & ~fifo_empty);

    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        emit     = 1'b0;
        push     = 1'b0;
        row_done = 1'b0;

        unique case (state_q)
            IDLE:    emit = slot_full[rd_slot_q];
            PACK:    emit = 1'b1;
            default: emit = 1'b0;
        endcase

        if (emit && push_ok) begin
            push = 1'b1;
            if (widx_q == LAST_W) begin
                row_done = 1'b1;
                widx_d   = '0;
                // Other slot already complete: continue without a bubble.
                state_d  = slot_full[~rd_slot_q] ? PACK : IDLE;
            end else begin
                widx_d  = widx_q + W_ONE;
                state_d = PACK;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset and clr produce identical state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_mask_q <= '{default: '0};
            wp_q        <= '0;
            rd_slot_q   <= 1'b0;
            state_q     <= IDLE;
            widx_q      <= '0;
            ovf_q       <= 1'b0;
            rows_done_q <= '0;
        end else if (clr) begin
            slot_mask_q <= '{default: '0};
            wp_q        <= '0;
            rd_slot_q   <= 1'b0;
            state_q     <= IDLE;
            widx_q      <= '0;
            ovf_q       <= 1'b0;
            rows_done_q <= '0;
        end else begin
            slot_mask_q <= slot_mask_d;
            wp_q        <= wp_q ^ lane_we;
            state_q     <= state_d;
            widx_q      <= widx_d;
            if (row_done) begin
                rd_slot_q   <= ~rd_slot_q;
                rows_done_q <= rows_done_q + 16'd1;
            end
            if (|lane_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO.
    // -------------------------------------------------------------------------
    sync_fifo #(
        .W     (OW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .push  (push),
        .pop   (rread),
        .din   (row_words[widx_q]),
        .dout  (out_r),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign rvalid    = ~fifo_empty;
    assign ovf       = ovf_q;
    assign rows_done = rows_done_q;

endmodule

// File: tb/tb_col_output_packer.sv
// -----------------------------------------------------------------------------
// Directed testbench for col_output_packer with default parameters
// (NCOL=8, DW=8, OW=32, FDEPTH=4 -> 2 words per row).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// so a value read right after tick() reflects the state after that edge.
// -----------------------------------------------------------------------------
module tb_col_output_packer;

    localparam int NCOL   = 8;
    localparam int DW     = 8;
    localparam int OW     = 32;
    localparam int FDEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic          rread = 1'b0;
    logic [DW-1:0] in_r [NCOL];
    logic          in_v [NCOL];
    logic [OW-1:0] out_r;
    logic          rvalid;
    logic          ovf;
    logic [15:0]   rows_done;
    logic [2:0]    level;

    int errors = 0;
    int checks = 0;
    logic [OW-1:0] got_q [$];

    always #5 clk = ~clk;

    col_output_packer #(
        .NCOL   (NCOL),
        .DW     (DW),
        .OW     (OW),
        .FDEPTH (FDEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .in_r      (in_r),
        .in_v      (in_v),
        .rread     (rread),
        .out_r     (out_r),
        .rvalid    (rvalid),
        .ovf       (ovf),
        .rows_done (rows_done),
        .level     (level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NCOL; i++) begin
            in_v[i] = 1'b0;
            in_r[i] = '0;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Pop with rread held until empty or the cycle budget runs out.
    task automatic drain(input int max_cycles);
        rread = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (!rvalid) break;
            got_q.push_back(out_r);
            tick();
        end
        rread = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rread = 1'b0;
        rstn  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (10) tick();
        checks++; if (rvalid !== 1'b0)   begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        checks++; if (level !== 3'd0)    begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (rows_done !== 16'd0) begin errors++; $display("FAIL reset_rows_done: got %0d expected 0", rows_done); end
        checks++; if (out_r !== 32'h0)   begin errors++; $display("FAIL reset_out_r: got %h expected 00000000", out_r); end
        // Pop while empty is ignored.
        rread = 1'b1;
        tick();
        rread = 1'b0;
        checks++; if (level !== 3'd0 || rvalid !== 1'b0) begin errors++; $display("FAIL empty_pop: got level=%0d rvalid=%b expected 0/0", level, rvalid); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single_row();
        idle_inputs();
        for (int i = 0; i < NCOL; i++) in_r[i] = DW'(i + 1);
        for (int j = 0; j < NCOL; j++) begin
            for (int k = 0; k < NCOL; k++) in_v[k] = (k == j);
            tick();                                     // edge j
        end
        idle_inputs();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_lvl_e7: got %0d expected 0", level); end
        tick();                                         // edge 8
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_lvl_e8: got %0d expected 1", level); end
        checks++; if (out_r !== 32'h04030201) begin errors++; $display("FAIL single_w0_e8: got %h expected 04030201", out_r); end
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid_e8: got %b expected 1", rvalid); end
        checks++; if (rows_done !== 16'd0) begin errors++; $display("FAIL single_rows_e8: got %0d expected 0", rows_done); end
        tick();                                         // edge 9
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL single_lvl_e9: got %0d expected 2", level); end
        checks++; if (rows_done !== 16'd1) begin errors++; $display("FAIL single_rows_e9: got %0d expected 1", rows_done); end
        rread = 1'b1;
        tick();
        checks++; if (out_r !== 32'h08070605 || level !== 3'd1) begin errors++; $display("FAIL single_pop1: got %h/%0d expected 08070605/1", out_r, level); end
        tick();
        rread = 1'b0;
        checks++; if (rvalid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL single_pop2: got rvalid=%b level=%0d expected 0/0", rvalid, level); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_overlap();
        logic [OW-1:0] exp_w [4];
        exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605;
        exp_w[2] = 32'h14131211; exp_w[3] = 32'h18171615;
        do_clr();
        got_q.delete();
        idle_inputs();
        rread = 1'b1;
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < NCOL; k++) in_v[k] = 1'b0;
            if (c < NCOL) begin
                in_v[c] = 1'b1;
                in_r[c] = DW'(8'h01 + c);
            end
            if (c >= 1 && c <= NCOL) begin
                in_v[c-1] = 1'b1;
                in_r[c-1] = DW'(8'h11 + c - 1);
            end
            if (rvalid) got_q.push_back(out_r);
            tick();
        end
        rread = 1'b0;
        idle_inputs();
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL overlap_count: got %0d words expected 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) begin
                checks++; if (got_q[i] !== exp_w[i]) begin errors++; $display("FAIL overlap_word%0d: got %h expected %h", i, got_q[i], exp_w[i]); end
            end
        end
        checks++; if (rows_done !== 16'd2) begin errors++; $display("FAIL overlap_rows: got %0d expected 2", rows_done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL overlap_ovf: got %b expected 0", ovf); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL overlap_level: got %0d expected 0", level); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        do_clr();
        idle_inputs();
        rread = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < NCOL; j++) begin
                for (int k = 0; k < NCOL; k++) in_v[k] = (k == j);
                in_r[j] = DW'(8'h21 + 16 * r + j);
                tick();                                 // edge 8r+j
            end
        end
        idle_inputs();
        tick();                                         // edge 24
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level_full: got %0d expected 4", level); end
        checks++; if (rows_done !== 16'd2) begin errors++; $display("FAIL bp_rows_stall: got %0d expected 2", rows_done); end
        checks++; if (out_r !== 32'h24232221) begin errors++; $display("FAIL bp_head: got %h expected 24232221", out_r); end
        tick();
        tick();
        checks++; if (level !== 3'd4 || rows_done !== 16'd2) begin errors++; $display("FAIL bp_hold: got level=%0d rows=%0d expected 4/2", level, rows_done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_pre: got %b expected 0", ovf); end
        // Fourth lane-0 datum lands in the free slot S1.
        in_v[0] = 1'b1; in_r[0] = 8'h51;
        tick();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_s1: got %b expected 0", ovf); end
        // Fifth lane-0 datum targets S0, still holding row 3.
        in_r[0] = 8'h61;
        tick();
        idle_inputs();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_set: got %b expected 1", ovf); end
    endtask

    // -------------------------------------------------------------------------
    // Continues from test_backpressure: FIFO full with the packer waiting.
    task automatic test_full_push_pop();
        logic [OW-1:0] exp_w [5];
        exp_w[0] = 32'h28272625; exp_w[1] = 32'h34333231; exp_w[2] = 32'h38373635;
        exp_w[3] = 32'h44434241; exp_w[4] = 32'h48474645;
        checks++; if (out_r !== 32'h24232221) begin errors++; $display("FAIL fpp_head: got %h expected 24232221", out_r); end
        rread = 1'b1;
        tick();
        rread = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_level: got %0d expected 4", level); end
        checks++; if (out_r !== 32'h28272625) begin errors++; $display("FAIL fpp_next: got %h expected 28272625", out_r); end
        got_q.delete();
        drain(30);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL fpp_count: got %0d words expected 5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) begin
                checks++; if (got_q[i] !== exp_w[i]) begin errors++; $display("FAIL fpp_word%0d: got %h expected %h", i, got_q[i], exp_w[i]); end
            end
        end
        checks++; if (rows_done !== 16'd3) begin errors++; $display("FAIL fpp_rows: got %0d expected 3", rows_done); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL fpp_level_end: got %0d expected 0", level); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL fpp_ovf_sticky: got %b expected 1", ovf); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_clr_mid_row();
        idle_inputs();
        rread = 1'b0;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < NCOL; k++) in_v[k] = (k == j);
            in_r[j] = 8'h99;
            tick();
        end
        idle_inputs();
        do_clr();
        checks++; if (level !== 3'd0 || rvalid !== 1'b0) begin errors++; $display("FAIL clr_fifo: got level=%0d rvalid=%b expected 0/0", level, rvalid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", ovf); end
        checks++; if (rows_done !== 16'd0) begin errors++; $display("FAIL clr_rows: got %0d expected 0", rows_done); end
        checks++; if (out_r !== 32'h0) begin errors++; $display("FAIL clr_out_r: got %h expected 00000000", out_r); end
        for (int j = 0; j < NCOL; j++) begin
            for (int k = 0; k < NCOL; k++) in_v[k] = (k == j);
            in_r[j] = DW'(8'h71 + j);
            tick();
        end
        idle_inputs();
        tick();
        checks++; if (level !== 3'd1 || out_r !== 32'h74737271) begin errors++; $display("FAIL clr_row_w0: got %h/%0d expected 74737271/1", out_r, level); end
        tick();
        checks++; if (level !== 3'd2 || rows_done !== 16'd1) begin errors++; $display("FAIL clr_row_done: got level=%0d rows=%0d expected 2/1", level, rows_done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_row_ovf: got %b expected 0", ovf); end
        got_q.delete();
        drain(10);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL clr_row_count: got %0d words expected 2", got_q.size()); end
        else begin
            checks++; if (got_q[1] !== 32'h78777675) begin errors++; $display("FAIL clr_row_w1: got %h expected 78777675", got_q[1]); end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        idle_inputs();
        test_reset();
        test_single_row();
        test_overlap();
        test_backpressure();
        test_full_push_pop();
        test_clr_mid_row();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
